control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired sequencer that drives every control input of the Mini-SRC datapath from the instruction held in IR and from the CON FF result.
- It is the producer side of the datapath control interface: fetch, decode and execute are issued as a Moore FSM, one control step per clock.
- Registers in the datapath capture on the rising edge that ends each step.

Parameters:
MEM_WAIT, 1, number of Read-only wait cycles before MDRin in any memory read; legal range 0..7.
HALT_ON_ILLEGAL, 0, 1 = opcodes 11100..11111 halt; 0 = they execute as nop.

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
ir  input  32  IR contents (ControlIn_IR)
con  input  1  CON FF output
stop  input  1  halt request, sampled at end of each instruction
run  output  1  1 while executing, 0 in HALT and during clear
PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, InportOut  output  1 each  bus source selects
MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, OutportIn, Conin  output  1 each  register enables
IncPC, Read, Write  output  1 each  PC increment, MDR mux select / memory read, memory write
GRA, GRB, GRC, Rin, Rout, BAout  output  1 each  select/encode controls
opcode  output  5  ALU operation

Behaviour:
- Reset: clear high forces state=T0, wait counter=0, and all outputs to 0, including run, asynchronously. First active step is T0 on the first rising edge after clear falls; run=1 from then.
- Outputs are a combinational decode of the registered state and ir[31:27]. Only signals listed for a step are 1; all others are 0.
- opcode output:
  - ir[31:27] in ALU-compute steps.
  - 00011 (ADD) in address/branch-target steps.
  - 11010 otherwise.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: Read; held MEM_WAIT cycles by a 3-bit counter. With MEM_WAIT=0, T1 is skipped.
  - T2: Read, MDRin.
  - T3: MDRout, IRin.
  - T4 decodes the IR value now valid.
- Execute by class (T4 onward). Last step returns to T0:
  - add/sub/and/or/shr/shra/shl/ror/rol (00011-01011): T4 GRB Rout Yin; T5 GRC Rout Zin; T6 Zlowout GRA Rin.
  - addi/andi/ori (01100-01110): T4 GRB Rout Yin; T5 Cout Zin; T6 Zlowout GRA Rin.
  - ldi (00001): T4 GRB BAout Yin; T5 Cout Zin(ADD); T6 Zlowout GRA Rin.
  - ld (00000): same T4-T5; T6 Zlowout MARin; memory read uses the same wait rule as fetch (Read ×MEM_WAIT, then Read MDRin); then MDRout GRA Rin.
  - st (00010): T4-T5 as ld; T6 Zlowout MARin; T7 GRA Rout MDRin (Read=0, bus path); T8 Write.
  - mul/div (01111, 10000): T4 GRA Rout Yin; T5 GRB Rout Zin; T6 LOin HIin.
  - neg/not (10001, 10010): T4 GRB Rout Zin; T5 Zlowout GRA Rin.
  - br (10011): T4 GRA Rout Conin; T5 PCout Yin; T6 Cout Zin(ADD); T7 Zlowout PCin only if con=1.
    - con is sampled in T7; T7 still occupies one cycle when con=0.
  - jr (10100): T4 GRA Rout PCin.
  - jal (10101): T4 PCout GRB Rin (link = incremented PC); T5 GRA Rout PCin.
  - in (10110): T4 InportOut GRA Rin.
  - out (10111): T4 GRA Rout OutportIn.
  - mfhi/mflo (11000/11001): T4 HIout (resp. LOout) GRA Rin.
  - nop (11010): T4 with no signals asserted, then T0.
  - halt (11011): enter HALT.
  - illegal opcodes: handled per HALT_ON_ILLEGAL.
- HALT: all outputs 0, run=0, state held until clear. Nothing else resumes.
- stop is sampled on the edge leaving each instruction's last step. stop=1 enters HALT instead of T0; stop=0 continues to T0. Pulses that fall outside that edge are ignored.
- clear mid-instruction: the instruction is abandoned with no partial Write/Rin pulse. Restart is at T0.
- Each step lasts exactly one cycle except the memory wait states.

Test Plan:
- Reset: assert clear for 3 cycles mid-T5 of an add -> all outputs 0 and run=0 immediately; first cycle after release shows PCout=MARin=IncPC=1.
- add r1,r2,r3, ir=0x18918000, MEM_WAIT=1 -> 7-cycle instruction (T0,T1,T2,T3,T4,T5,T6); T5 opcode=00011 with GRC=Rout=Zin=1; T6 Zlowout=GRA=Rin=1.
- ld r1,0x54(r2), ir=0x00900054, MEM_WAIT=1 -> T4 BAout=1; T5 opcode=00011 with Cout=1; exactly two memory-read cycles with Read=1 before the MDRout/GRA/Rin step; Write never 1.
- brzr r2,0x23, ir=0x99000023 -> with con=1 T7 PCin=1; with con=0 T7 all outputs 0; both paths return to T0 after T7.
- mul r3,r4, ir=0x79A00000 -> T6 has LOin=HIin=1 and Rin=0; next cycle is T0.
- halt, ir=0xD8000000, then 20 idle cycles -> run=0 and no output toggles; clear then release -> T0 fetch resumes.

Source files
------------

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if
// Control bundle between the Mini-SRC hardwired sequencer and its datapath.
//   ir, con, stop    : datapath -> sequencer (instruction, CON FF, halt request)
//   run              : sequencer status, 1 while executing
//   *out, Cout       : bus source selects
//   *in, Conin       : register capture enables
//   IncPC/Read/Write : PC increment, MDR mux / memory read, memory write
//   GRA..BAout       : register-file select/encode controls
//   opcode           : ALU operation
// master = control unit, slave = datapath.
// -----------------------------------------------------------------------------
interface control_unit_if;
   logic [31:0] ir;
   logic        con;
   logic        stop;
   logic        run;
   logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, InportOut;
   logic        MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, OutportIn, Conin;
   logic        IncPC, Read, Write;
   logic        GRA, GRB, GRC, Rin, Rout, BAout;
   logic [4:0]  opcode;

   modport master (
      input  ir, con, stop,
      output run,
      output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, InportOut,
      output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, OutportIn, Conin,
      output IncPC, Read, Write,
      output GRA, GRB, GRC, Rin, Rout, BAout,
      output opcode
   );

   modport slave (
      output ir, con, stop,
      input  run,
      input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, InportOut,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, OutportIn, Conin,
      input  IncPC, Read, Write,
      input  GRA, GRB, GRC, Rin, Rout, BAout,
      input  opcode
   );
endinterface

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Hardwired Moore sequencer for the Mini-SRC datapath. One control step per
// clock: fetch (T0-T3), then class-dependent execute steps from T4 onward.
// Ports:
//   clock : rising-edge system clock
//   clear : asynchronous active-high reset (all outputs and run forced to 0)
//   cu    : control bundle (master side), see control_unit_if
// Parameters:
//   MEM_WAIT        : Read-only wait cycles before MDRin on a memory read (0..7)
//   HALT_ON_ILLEGAL : 1 = opcodes 11100..11111 halt, 0 = they act as nop
// -----------------------------------------------------------------------------
module control_unit #(
   parameter int unsigned MEM_WAIT        = 1,
   parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
   input logic            clock,
   input logic            clear,
   control_unit_if.master cu
);

   localparam logic [4:0] OP_ADD = 5'b00011;
   localparam logic [4:0] OP_NOP = 5'b11010;
   localparam logic [2:0] WAIT_LAST = (MEM_WAIT == 0) ? 3'd0 : 3'(MEM_WAIT - 1);

   typedef enum logic [3:0] {
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_T9, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT, C_BR,
      C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } class_t;

   state_t     state_q;
   logic [2:0] wait_q;
   logic       run_q;
   class_t     cls;
   state_t     last_state;
   logic       is_last;
   logic [4:0] opc;

   assign opc = cu.ir[31:27];

   // Instruction class from the opcode field.
   always_comb begin
      cls = C_NOP;
      case (opc)
         5'd0:  cls = C_LD;
         5'd1:  cls = C_LDI;
         5'd2:  cls = C_ST;
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: cls = C_ALU;
         5'd12, 5'd13, 5'd14: cls = C_IMM;
         5'd15, 5'd16: cls = C_MULDIV;
         5'd17, 5'd18: cls = C_NEGNOT;
         5'd19: cls = C_BR;
         5'd20: cls = C_JR;
         5'd21: cls = C_JAL;
         5'd22: cls = C_IN;
         5'd23: cls = C_OUT;
         5'd24: cls = C_MFHI;
         5'd25: cls = C_MFLO;
         5'd26: cls = C_NOP;
         5'd27: cls = C_HALT;
         default: cls = HALT_ON_ILLEGAL ? C_HALT : C_NOP;
      endcase
   end

   // Final execute step of each class; stop is honoured on the edge leaving it.
   always_comb begin
      last_state = S_T4;
      case (cls)
         C_ALU, C_IMM, C_LDI, C_MULDIV: last_state = S_T6;
         C_LD:                          last_state = S_T9;
         C_ST:                          last_state = S_T8;
         C_NEGNOT, C_JAL:               last_state = S_T5;
         C_BR:                          last_state = S_T7;
         default:                       last_state = S_T4;
      endcase
   end

   assign is_last = (state_q == last_state);

   // run_q stays low for the first edge after clear so the first active step
   // is a full T0; HALT is sticky until clear.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= S_T0;
         wait_q  <= 3'd0;
         run_q   <= 1'b0;
      end else if (state_q == S_HALT) begin
         state_q <= S_HALT;
      end else if (!run_q) begin
         run_q <= 1'b1;
      end else begin
         case (state_q)
            S_T0: state_q <= (MEM_WAIT == 0) ? S_T2 : S_T1;
            S_T1: begin
               if (wait_q == WAIT_LAST) begin
                  wait_q  <= 3'd0;
                  state_q <= S_T2;
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            S_T2: state_q <= S_T3;
            S_T3: state_q <= S_T4;
            default: begin
               if (state_q == S_T4 && cls == C_HALT) begin
                  state_q <= S_HALT;
                  run_q   <= 1'b0;
               end else if (is_last) begin
                  if (cu.stop) begin
                     state_q <= S_HALT;
                     run_q   <= 1'b0;
                  end else begin
                     state_q <= S_T0;
                  end
               end else if (cls == C_LD && state_q == S_T6) begin
                  state_q <= (MEM_WAIT == 0) ? S_T8 : S_T7;
               end else if (cls == C_LD && state_q == S_T7) begin
                  // operand-read wait states reuse the fetch counter
                  if (wait_q == WAIT_LAST) begin
                     wait_q  <= 3'd0;
                     state_q <= S_T8;
                  end else begin
                     wait_q <= wait_q + 3'd1;
                  end
               end else begin
                  case (state_q)
                     S_T4:    state_q <= S_T5;
                     S_T5:    state_q <= S_T6;
                     S_T6:    state_q <= S_T7;
                     S_T7:    state_q <= S_T8;
                     S_T8:    state_q <= S_T9;
                     default: state_q <= S_T0;
                  endcase
               end
            end
         endcase
      end
   end

   assign cu.run = run_q;

   // Control decode; everything is forced low while not running (clear/HALT).
   always_comb begin
      cu.PCout = 1'b0; cu.Zlowout = 1'b0; cu.Zhighout = 1'b0; cu.MDRout = 1'b0;
      cu.HIout = 1'b0; cu.LOout = 1'b0; cu.Cout = 1'b0; cu.InportOut = 1'b0;
      cu.MARin = 1'b0; cu.Zin = 1'b0; cu.PCin = 1'b0; cu.MDRin = 1'b0;
      cu.IRin = 1'b0; cu.Yin = 1'b0; cu.LOin = 1'b0; cu.HIin = 1'b0;
      cu.OutportIn = 1'b0; cu.Conin = 1'b0;
      cu.IncPC = 1'b0; cu.Read = 1'b0; cu.Write = 1'b0;
      cu.GRA = 1'b0; cu.GRB = 1'b0; cu.GRC = 1'b0;
      cu.Rin = 1'b0; cu.Rout = 1'b0; cu.BAout = 1'b0;
      cu.opcode = 5'b00000;
      if (run_q) begin
         cu.opcode = OP_NOP;
         case (state_q)
            S_T0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; end
            S_T1: cu.Read = 1'b1;
            S_T2: begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
            S_T3: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
            S_T4: begin
               case (cls)
                  C_ALU, C_IMM: begin cu.GRB = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
                  C_LDI, C_LD, C_ST: begin cu.GRB = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
                  C_MULDIV: begin cu.GRA = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
                  C_NEGNOT: begin
                     cu.GRB = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.opcode = opc;
                  end
                  C_BR:   begin cu.GRA = 1'b1; cu.Rout = 1'b1; cu.Conin = 1'b1; end
                  C_JR:   begin cu.GRA = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
                  C_JAL:  begin cu.PCout = 1'b1; cu.GRB = 1'b1; cu.Rin = 1'b1; end
                  C_IN:   begin cu.InportOut = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1; end
                  C_OUT:  begin cu.GRA = 1'b1; cu.Rout = 1'b1; cu.OutportIn = 1'b1; end
                  C_MFHI: begin cu.HIout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1; end
                  C_MFLO: begin cu.LOout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1; end
                  default: ;
               endcase
            end
            S_T5: begin
               case (cls)
                  C_ALU: begin
                     cu.GRC = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.opcode = opc;
                  end
                  C_IMM: begin cu.Cout = 1'b1; cu.Zin = 1'b1; cu.opcode = opc; end
                  C_LDI, C_LD, C_ST: begin cu.Cout = 1'b1; cu.Zin = 1'b1; cu.opcode = OP_ADD; end
                  C_MULDIV: begin
                     cu.GRB = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.opcode = opc;
                  end
                  C_NEGNOT: begin cu.Zlowout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1; end
                  C_BR:     begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
                  C_JAL:    begin cu.GRA = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
                  default: ;
               endcase
            end
            S_T6: begin
               case (cls)
                  C_ALU, C_IMM, C_LDI: begin cu.Zlowout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1; end
                  C_LD, C_ST: begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
                  C_MULDIV:   begin cu.LOin = 1'b1; cu.HIin = 1'b1; end
                  C_BR:       begin cu.Cout = 1'b1; cu.Zin = 1'b1; cu.opcode = OP_ADD; end
                  default: ;
               endcase
            end
            S_T7: begin
               case (cls)
                  C_LD: cu.Read = 1'b1;
                  // store data comes over the bus, so the MDR mux stays on bus
                  C_ST: begin cu.GRA = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
                  C_BR: begin cu.Zlowout = cu.con; cu.PCin = cu.con; end
                  default: ;
               endcase
            end
            S_T8: begin
               if (cls == C_LD) begin
                  cu.Read = 1'b1; cu.MDRin = 1'b1;
               end else if (cls == C_ST) begin
                  cu.Write = 1'b1;
               end
            end
            S_T9: begin
               if (cls == C_LD) begin
                  cu.MDRout = 1'b1; cu.GRA = 1'b1; cu.Rin = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

   localparam int unsigned MW = 1;
   localparam logic [4:0] OP_NOP = 5'b11010;
   localparam logic [4:0] OP_ADD = 5'b00011;

   // bit positions of the packed control word (opcode sits above bit 26)
   localparam logic [26:0] M_PCOUT     = 27'd1 << 0;
   localparam logic [26:0] M_ZLOWOUT   = 27'd1 << 1;
   localparam logic [26:0] M_ZHIGHOUT  = 27'd1 << 2;
   localparam logic [26:0] M_MDROUT    = 27'd1 << 3;
   localparam logic [26:0] M_HIOUT     = 27'd1 << 4;
   localparam logic [26:0] M_LOOUT     = 27'd1 << 5;
   localparam logic [26:0] M_COUT      = 27'd1 << 6;
   localparam logic [26:0] M_INPORTOUT = 27'd1 << 7;
   localparam logic [26:0] M_MARIN     = 27'd1 << 8;
   localparam logic [26:0] M_ZIN       = 27'd1 << 9;
   localparam logic [26:0] M_PCIN      = 27'd1 << 10;
   localparam logic [26:0] M_MDRIN     = 27'd1 << 11;
   localparam logic [26:0] M_IRIN      = 27'd1 << 12;
   localparam logic [26:0] M_YIN       = 27'd1 << 13;
   localparam logic [26:0] M_LOIN      = 27'd1 << 14;
   localparam logic [26:0] M_HIIN      = 27'd1 << 15;
   localparam logic [26:0] M_OUTPORTIN = 27'd1 << 16;
   localparam logic [26:0] M_CONIN     = 27'd1 << 17;
   localparam logic [26:0] M_INCPC     = 27'd1 << 18;
   localparam logic [26:0] M_READ      = 27'd1 << 19;
   localparam logic [26:0] M_WRITE     = 27'd1 << 20;
   localparam logic [26:0] M_GRA       = 27'd1 << 21;
   localparam logic [26:0] M_GRB       = 27'd1 << 22;
   localparam logic [26:0] M_GRC       = 27'd1 << 23;
   localparam logic [26:0] M_RIN       = 27'd1 << 24;
   localparam logic [26:0] M_ROUT      = 27'd1 << 25;
   localparam logic [26:0] M_BAOUT     = 27'd1 << 26;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   control_unit_if bus ();

   control_unit #(
      .MEM_WAIT(MW),
      .HALT_ON_ILLEGAL(1'b0)
   ) dut (
      .clock(clock),
      .clear(clear),
      .cu(bus)
   );

   logic [31:0] dut_word;
   assign dut_word = {bus.opcode, bus.BAout, bus.Rout, bus.Rin, bus.GRC, bus.GRB, bus.GRA,
                      bus.Write, bus.Read, bus.IncPC, bus.Conin, bus.OutportIn, bus.HIin,
                      bus.LOin, bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.Zin, bus.MARin,
                      bus.InportOut, bus.Cout, bus.LOout, bus.HIout, bus.MDRout,
                      bus.Zhighout, bus.Zlowout, bus.PCout};

   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];
   int con_idx;
   bit halts;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [26:0] ctrl, input logic [4:0] op);
      exp_q.push_back({op, ctrl});
   endtask

   task automatic push_mem_read();
      repeat (MW) push(M_READ, OP_NOP);
      push(M_READ | M_MDRIN, OP_NOP);
   endtask

   // Reference: expected per-cycle control words for one whole instruction.
   task automatic build_seq(input logic [31:0] iv, input bit cv);
      logic [4:0] opc;
      int o;
      exp_q.delete();
      con_idx = -1;
      halts = 1'b0;
      opc = iv[31:27];
      o = int'(opc);
      push(M_PCOUT | M_MARIN | M_INCPC, OP_NOP);
      push_mem_read();
      push(M_MDROUT | M_IRIN, OP_NOP);
      if (o <= 2) begin
         push(M_GRB | M_BAOUT | M_YIN, OP_NOP);
         push(M_COUT | M_ZIN, OP_ADD);
         if (o == 1) begin
            push(M_ZLOWOUT | M_GRA | M_RIN, OP_NOP);
         end else begin
            push(M_ZLOWOUT | M_MARIN, OP_NOP);
            if (o == 0) begin
               push_mem_read();
               push(M_MDROUT | M_GRA | M_RIN, OP_NOP);
            end else begin
               push(M_GRA | M_ROUT | M_MDRIN, OP_NOP);
               push(M_WRITE, OP_NOP);
            end
         end
      end else if (o <= 11) begin
         push(M_GRB | M_ROUT | M_YIN, OP_NOP);
         push(M_GRC | M_ROUT | M_ZIN, opc);
         push(M_ZLOWOUT | M_GRA | M_RIN, OP_NOP);
      end else if (o <= 14) begin
         push(M_GRB | M_ROUT | M_YIN, OP_NOP);
         push(M_COUT | M_ZIN, opc);
         push(M_ZLOWOUT | M_GRA | M_RIN, OP_NOP);
      end else if (o <= 16) begin
         push(M_GRA | M_ROUT | M_YIN, OP_NOP);
         push(M_GRB | M_ROUT | M_ZIN, opc);
         push(M_LOIN | M_HIIN, OP_NOP);
      end else if (o <= 18) begin
         push(M_GRB | M_ROUT | M_ZIN, opc);
         push(M_ZLOWOUT | M_GRA | M_RIN, OP_NOP);
      end else if (o == 19) begin
         push(M_GRA | M_ROUT | M_CONIN, OP_NOP);
         push(M_PCOUT | M_YIN, OP_NOP);
         push(M_COUT | M_ZIN, OP_ADD);
         con_idx = exp_q.size();
         push(cv ? (M_ZLOWOUT | M_PCIN) : 27'd0, OP_NOP);
      end else if (o == 20) push(M_GRA | M_ROUT | M_PCIN, OP_NOP);
      else if (o == 21) begin
         push(M_PCOUT | M_GRB | M_RIN, OP_NOP);
         push(M_GRA | M_ROUT | M_PCIN, OP_NOP);
      end
      else if (o == 22) push(M_INPORTOUT | M_GRA | M_RIN, OP_NOP);
      else if (o == 23) push(M_GRA | M_ROUT | M_OUTPORTIN, OP_NOP);
      else if (o == 24) push(M_HIOUT | M_GRA | M_RIN, OP_NOP);
      else if (o == 25) push(M_LOOUT | M_GRA | M_RIN, OP_NOP);
      else if (o == 27) begin
         push(27'd0, OP_NOP);
         halts = 1'b1;
      end else push(27'd0, OP_NOP);   // nop and illegal opcodes
   endtask

   // Called at a negedge; leaves clear released at a negedge.
   task automatic do_clear(input int n);
      clear = 1'b1;
      #1;
      check_val("clr_word", dut_word, 32'd0);
      check_val("clr_run", {31'd0, bus.run}, 32'd0);
      repeat (n) begin
         @(negedge clock);
         check_val("clr_hold", dut_word, 32'd0);
      end
      clear = 1'b0;
   endtask

   task automatic halt_phase();
      repeat (20) begin
         @(negedge clock);
         check_val("halt_word", dut_word, 32'd0);
         check_val("halt_run", {31'd0, bus.run}, 32'd0);
         bus.ir = $urandom;
         bus.con = 1'($urandom);
         bus.stop = 1'($urandom);
      end
      do_clear(2);
   endtask

   task automatic run_instr(input logic [31:0] iv, input bit cv, input bit sv, input int abort_at);
      build_seq(iv, cv);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clock);
         check_val($sformatf("op%02h_t%0d", iv[31:27], i), dut_word, exp_q[i]);
         check_val($sformatf("run_t%0d", i), {31'd0, bus.run}, 32'd1);
         if (i == abort_at) begin
            do_clear(3);
            return;
         end
         if (exp_q[i][12]) bus.ir = iv;   // datapath loads IR at the end of this step
         bus.con = (i + 1 == con_idx) ? cv : 1'($urandom);
         bus.stop = (i == exp_q.size() - 1) ? sv : 1'($urandom);
      end
      if (halts || sv) halt_phase();
   endtask

   initial begin
      int o;
      logic [31:0] iv;
      bus.ir = 32'd0;
      bus.con = 1'b0;
      bus.stop = 1'b0;
      clear = 1'b1;
      #2;
      check_val("rst_word", dut_word, 32'd0);
      check_val("rst_run", {31'd0, bus.run}, 32'd0);
      repeat (2) @(negedge clock);
      clear = 1'b0;

      run_instr(32'h18918000, 1'b0, 1'b0, 5);   // add, clear mid-T5
      run_instr(32'h18918000, 1'b0, 1'b0, -1);  // add
      run_instr(32'h00900054, 1'b0, 1'b0, -1);  // ld
      run_instr(32'h99000023, 1'b1, 1'b0, -1);  // br taken
      run_instr(32'h99000023, 1'b0, 1'b0, -1);  // br not taken
      run_instr(32'h79A00000, 1'b0, 1'b0, -1);  // mul
      run_instr(32'h18918000, 1'b0, 1'b1, -1);  // stop at end -> HALT

      repeat (150) begin
         do o = int'($urandom_range(0, 31)); while (o == 27);
         iv = {o[4:0], 27'($urandom)};
         run_instr(iv, 1'($urandom), ($urandom_range(0, 15) == 0), -1);
      end

      run_instr(32'hD8000000, 1'b0, 1'b0, -1);  // halt, idle, clear
      run_instr(32'h18918000, 1'b0, 1'b0, -1);  // fetch resumes

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
